// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch and data access.
// One access is in flight at a time; data wins ties unless fetch has been starved too long.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int              CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(MEM_LAT - 1);
  localparam logic [3:0]      STREAK_MAX = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic              r_owner_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_streak;

  logic w_arb;
  logic w_if_win;
  logic w_if_gnt;
  logic w_d_gnt;

  // Arbitration is only open while no access occupies the memory (IDLE) or while the
  // previous one is being handed back (RESP), which gives back-to-back throughput.
  assign w_arb    = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_if_win = if_req && (!d_req || (r_streak == STREAK_MAX));
  assign w_if_gnt = w_arb && w_if_win;
  assign w_d_gnt  = w_arb && d_req && !w_if_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_cnt      <= '0;
      r_streak   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_if_gnt) begin
            r_state   <= S_ISSUE;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= if_addr;
            r_streak  <= '0;
          end else if (w_d_gnt) begin
            r_state   <= S_ISSUE;
            r_owner_d <= 1'b1;
            r_we      <= d_we;
            r_addr    <= d_addr;
            r_wdata   <= d_wdata;
            // Only grants won against a waiting fetch count toward starvation.
            if (!if_req) begin
              r_streak <= '0;
            end else if (r_streak != STREAK_MAX) begin
              r_streak <= r_streak + 4'd1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= CNT_INIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
            if (!r_we) begin
              if (r_owner_d) begin
                r_d_rdata <= mem_rdata;
              end else begin
                r_if_rdata <= mem_rdata;
              end
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state so an asynchronous reset removes them at once.
  assign mem_en    = (r_state == S_ISSUE);
  assign mem_we    = (r_state == S_ISSUE) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = (r_state == S_RESP) && !r_owner_d;
  assign d_rvalid  = (r_state == S_RESP) && r_owner_d;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequencer and arbiter that shares one single-ported, fixed-latency unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage: loads and stores). It runs one access at a time through an issue/wait/response sequence. It gives the data port priority, bounded by a starvation guard for fetch. It sits between the pipeline stages and the memory array; stages stall until their `*_rvalid`.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 1, memory read latency in cycles, counted from the edge ending ISSUE (legal 1..8).
- `MAX_D_STREAK`, 4, consecutive contested data grants before fetch is forced to win (legal 1..15).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch granted (combinational, one cycle).
- `if_rvalid` out 1: one-cycle fetch completion.
- `if_rdata` out DATA_W: fetched word, valid with `if_rvalid`.
- `d_req` in 1: data request; held until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_gnt` out 1: data granted (combinational, one cycle).
- `d_rvalid` out 1: one-cycle load data / store ack.
- `d_rdata` out DATA_W: load data, valid with `d_rvalid`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high when state is not IDLE.

## Operation
- State machine IDLE, ISSUE, WAIT, RESP. Internal registers: owner (IF/D), latched addr/we/wdata, latency counter `cnt`, `streak`.
- Arbitration runs only in IDLE and RESP. With no request, RESP goes to IDLE.
- Grant rule: data wins unless `if_req`=1 and `streak`=MAX_D_STREAK, in which case fetch wins. A single requester always wins.
- A grant drives `*_gnt`=1 combinationally that cycle. At the edge, the request is latched, owner is set, and the state goes to ISSUE.
- `streak` update: +1 on a data grant with `if_req`=1. Cleared on a fetch grant and on a data grant with `if_req`=0.
- ISSUE (1 cycle): `mem_en`=1, `mem_we`=latched we (0 for fetch), and `mem_addr`/`mem_wdata` driven from latches. Next state is WAIT, with `cnt`=MEM_LAT-1.
- WAIT: `cnt` decrements each cycle. When `cnt`=0, `mem_rdata` is valid. At that edge it is captured into the owner's rdata register (loads/fetches only), and the state goes to RESP.
- RESP: the owner's `*_rvalid`=1 for exactly this cycle. Store: `d_rvalid`=1 and `d_rdata` holds its previous value.
- Outside ISSUE, `mem_en`=`mem_we`=0. `mem_addr`/`mem_wdata` keep their last value.
- A request dropped before its grant is ignored. No queueing; at most one access is outstanding.

## Timing
- Reset values: state IDLE, all `*_gnt`/`*_rvalid`/`mem_en`/`mem_we`/`busy`=0, `if_rdata`/`d_rdata`/`mem_addr`/`mem_wdata`=0, `streak`=0, `cnt`=0.
- Request in IDLE at cycle 0: gnt at cycle 0, ISSUE at cycle 1, WAIT cycles 2..MEM_LAT+1, rvalid at cycle MEM_LAT+2.
- Back-to-back: the next grant occurs in the RESP cycle, so sustained throughput is one access per MEM_LAT+2 cycles.
- Simultaneous requests when `streak`<MAX: data wins and fetch waits one full access.
- Reset mid-operation (any state): immediate return to IDLE and `mem_en`/`mem_we` drop asynchronously. No rvalid is issued for the aborted access. A store aborted in ISSUE before the edge is not written.
- `streak` saturates at MAX_D_STREAK and never wraps. `cnt` is wide enough for MEM_LAT-1.
- Outputs `*_rvalid`, `*_rdata`, and `mem_*` are registered or decoded from state only. `*_gnt` is the only combinational output from `*_req`.

## Test plan
- Single fetch, MEM_LAT=1, `if_addr`=0x10, memory returns 0xDEADBEEF: `if_gnt`@0, `mem_en`@1 with `mem_addr`=0x10, `if_rvalid`@3 with `if_rdata`=0xDEADBEEF.
- Store then load, MEM_LAT=3: store 0x1234 to 0x20, then load 0x20. `mem_we`=1 only in the store ISSUE. `d_rvalid` arrives 5 cycles after each grant, and the load returns 0x1234.
- Both requesters held continuously, MAX_D_STREAK=4: grant order D,D,D,D,IF,D,D,D,D,IF, with each grant in a RESP cycle.
- Request dropped: `if_req` pulsed for one cycle while busy with a data access. No fetch is granted after RESP, and the state returns to IDLE.
- `reset` asserted during ISSUE of a store to 0x8: `mem_en`/`mem_we` drop immediately, there is no `d_rvalid`, the memory location is unchanged, and the next request after release is served normally.
- MEM_LAT=8 fetch: rvalid exactly 10 cycles after the grant, and `busy` is high for 10 cycles.
